// File: rtl/sys_defs.sv
// Shared definitions for the multiplier issue path: operand and function
// types, the request/result records, sizing constants and FSM states.
package sys_defs;

  typedef logic [31:0] DATA;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHU  = 2'd2,
    MULHSU = 2'd3
  } MULT_FUNC;

  localparam int MULT_TAG_W     = 6;
  localparam int MULT_RES_DEPTH = 2;

  // Operation held towards the mult unit while it works.
  typedef struct packed {
    DATA                   rs1;
    DATA                   rs2;
    MULT_FUNC              func;
    logic [MULT_TAG_W-1:0] tag;
  } MULT_REQ;

  // Tagged result waiting for a CDB grant.
  typedef struct packed {
    DATA                   result;
    logic [MULT_TAG_W-1:0] tag;
  } MULT_RES;

  typedef enum logic [1:0] {
    MI_IDLE  = 2'd0,
    MI_START = 2'd1,
    MI_BUSY  = 2'd2,
    MI_DRAIN = 2'd3
  } mult_issue_state_e;

  // Pointer width for a buffer of the given depth (at least one bit).
  function automatic int mult_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mult_result_fifo.sv
// Small FIFO of tagged multiply results. Flush empties it in one cycle and
// wins over push/pop; simultaneous push and pop leave the count unchanged.
module mult_result_fifo
  import sys_defs::*;
#(
  parameter int DEPTH = MULT_RES_DEPTH,
  localparam int PW = mult_ptr_w(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  MULT_RES       push_data,
  input  logic          pop,
  input  logic          flush,
  output MULT_RES       head,
  output logic          empty,
  output logic [CW-1:0] count
);

  MULT_RES       mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Qualify requests against occupancy so pointers never run past each other.
  always_comb begin
    do_push = push && (count_q != CW'(DEPTH));
    do_pop  = pop && (count_q != '0);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/mult_issue_ctrl.sv
// Initiator side of the multiplier start/done protocol. Takes one multiply
// from the issue port, pulses start, holds operands until done, and queues
// tagged results for the CDB. Squash kills the in-flight op and the queue.
// Optional build macro: MULT_CDB_BYPASS_EN drives the CDB straight from
// mult_result when the queue is empty in the done cycle.
//
// Handshakes: issue and CDB both transfer on a clock edge where valid and
// ready/grant are both high; valid never depends on ready/grant, and a
// transfer offered in a squash or reset cycle does not happen.
module mult_issue_ctrl
  import sys_defs::*;
#(
  parameter int TAG_W        = MULT_TAG_W,
  parameter int RESULT_DEPTH = MULT_RES_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  DATA               issue_rs1,
  input  DATA               issue_rs2,
  input  MULT_FUNC          issue_func,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic              squash,
  output logic              mult_start,
  output DATA               mult_rs1,
  output DATA               mult_rs2,
  output MULT_FUNC          mult_func,
  input  DATA               mult_result,
  input  logic              mult_done,
  output logic              cdb_valid,
  output DATA               cdb_result,
  output logic [TAG_W-1:0]  cdb_tag,
  input  logic              cdb_grant,
  output mult_issue_state_e dbg_state
);

  localparam int CW = $clog2(RESULT_DEPTH + 1);

  mult_issue_state_e state_q;
  MULT_REQ           req_q;
  logic              start_q;

  logic              accept;
  logic              done_ok;
  logic              bypass_hit;
  logic              bypass_taken;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  MULT_RES           fifo_head;
  MULT_RES           push_data;
  logic [CW-1:0]     fifo_count;

  // Issue acceptance and result routing decisions for this cycle.
  always_comb begin
    issue_ready = reset && (state_q == MI_IDLE) && !squash &&
                  (fifo_count < CW'(RESULT_DEPTH));
    accept      = issue_valid && issue_ready;
    done_ok     = (state_q == MI_BUSY) && mult_done && !squash;
`ifdef MULT_CDB_BYPASS_EN
    bypass_hit   = done_ok && fifo_empty;
    bypass_taken = bypass_hit && cdb_grant;
`else
    bypass_hit   = 1'b0;
    bypass_taken = 1'b0;
`endif
    fifo_push = done_ok && !bypass_taken;
    fifo_pop  = cdb_grant && !squash && !fifo_empty;
    push_data = '{result: mult_result, tag: req_q.tag};
  end

  // Single issue FSM; start pulse and held operands are registered here.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= MI_IDLE;
      req_q   <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        MI_IDLE: begin
          if (accept) begin
            req_q   <= '{rs1: issue_rs1, rs2: issue_rs2, func: issue_func, tag: issue_tag};
            start_q <= 1'b1;
            state_q <= MI_START;
          end
        end
        MI_START: state_q <= squash ? MI_DRAIN : MI_BUSY;
        MI_BUSY: begin
          if (mult_done)   state_q <= MI_IDLE;
          else if (squash) state_q <= MI_DRAIN;
        end
        MI_DRAIN: begin
          if (mult_done) state_q <= MI_IDLE;
        end
        default: state_q <= MI_IDLE;
      endcase
    end
  end

  mult_result_fifo #(
    .DEPTH(RESULT_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(push_data),
    .pop      (fifo_pop),
    .flush    (squash),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // CDB outputs come from the queue head unless the bypass path is live.
  always_comb begin
    cdb_valid  = !fifo_empty || bypass_hit;
    cdb_result = bypass_hit ? mult_result : fifo_head.result;
    cdb_tag    = bypass_hit ? req_q.tag : fifo_head.tag;
  end

  assign mult_start = start_q;
  assign mult_rs1   = req_q.rs1;
  assign mult_rs2   = req_q.rs2;
  assign mult_func  = req_q.func;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Bench for mult_issue_ctrl: behavioural mult unit, CDB scoreboard, vector
// table, hand-written corner sequences and a randomized phase.
module tb_mult_issue_ctrl;
  import sys_defs::*;

  localparam int TW = MULT_TAG_W;

  logic              clock = 1'b0;
  logic              reset;
  logic              issue_valid;
  logic              issue_ready;
  DATA               issue_rs1;
  DATA               issue_rs2;
  MULT_FUNC          issue_func;
  logic [TW-1:0]     issue_tag;
  logic              squash;
  logic              mult_start;
  DATA               mult_rs1;
  DATA               mult_rs2;
  MULT_FUNC          mult_func;
  DATA               mult_result;
  logic              mult_done;
  logic              cdb_valid;
  DATA               cdb_result;
  logic [TW-1:0]     cdb_tag;
  logic              cdb_grant;
  mult_issue_state_e dbg_state;

  int checks = 0;
  int errors = 0;
  int force_lat = 0;
  bit rand_grant = 0;
  logic [32+TW-1:0] exp_q[$];

  typedef struct {
    MULT_FUNC      f;
    DATA           a;
    DATA           b;
    logic [TW-1:0] t;
    DATA           exp;
  } vec_t;
  vec_t vecs[8];

  mult_issue_ctrl #(.TAG_W(TW), .RESULT_DEPTH(MULT_RES_DEPTH)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_func(issue_func),
    .issue_tag(issue_tag), .squash(squash),
    .mult_start(mult_start), .mult_rs1(mult_rs1), .mult_rs2(mult_rs2),
    .mult_func(mult_func), .mult_result(mult_result), .mult_done(mult_done),
    .cdb_valid(cdb_valid), .cdb_result(cdb_result), .cdb_tag(cdb_tag),
    .cdb_grant(cdb_grant), .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Architectural multiply: full 64-bit product, pick the half by function.
  function automatic DATA ref_mul(input MULT_FUNC f, input DATA a, input DATA b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] ub;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'b0, b};
    case (f)
      MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      default: begin p = sa * ub; return p[63:32]; end
    endcase
  endfunction

  // Behavioural mult unit: latches operands on start, answers after a delay.
  initial begin
    bit pend;
    int lat;
    DATA res;
    logic [65:0] ops;
    bit prev_start;
    pend = 0; lat = 0; prev_start = 0; res = '0; ops = '0;
    mult_done = 1'b0;
    mult_result = '0;
    forever begin
      @(negedge clock);
      mult_done = 1'b0;
      if (!reset) pend = 0;
      else if (pend) begin
        lat--;
        if (lat <= 0) begin
          mult_done = 1'b1;
          mult_result = res;
          pend = 0;
          chk("operand_hold", {mult_rs1, mult_rs2, mult_func}, ops);
        end
      end
      if (mult_start && reset) begin
        chk("start_pulse_width", prev_start, 0);
        pend = 1;
        ops = {mult_rs1, mult_rs2, mult_func};
        res = ref_mul(mult_func, mult_rs1, mult_rs2);
        lat = (force_lat > 0) ? force_lat : int'($urandom_range(1, 4));
      end
      prev_start = mult_start;
    end
  end

  // Scoreboard: every granted CDB transfer must match the oldest live op.
  initial begin
    logic [32+TW-1:0] e;
    forever begin
      @(negedge clock);
      #2;
      if (reset && !squash && cdb_valid && cdb_grant) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cdb_unexpected actual_tag=%0h required=none", cdb_tag);
        end else begin
          e = exp_q.pop_front();
          chk("cdb_result_tag", {cdb_result, cdb_tag}, e);
        end
      end
    end
  end

  // Random grant driver for the randomized phase.
  initial begin
    forever begin
      @(negedge clock);
      if (rand_grant) cdb_grant = 1'($urandom_range(0, 1));
    end
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic issue_op(input MULT_FUNC f, input DATA a, input DATA b,
                          input logic [TW-1:0] t, input DATA exp_r);
    int n;
    n = 0;
    @(negedge clock);
    issue_valid = 1'b1; issue_func = f; issue_rs1 = a; issue_rs2 = b; issue_tag = t;
    #1;
    while (!issue_ready && n < 100) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (!issue_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout actual=not_ready required=ready");
      issue_valid = 1'b0;
    end else begin
      exp_q.push_back({exp_r, t});
      @(posedge clock);
      #1;
      issue_valid = 1'b0;
      chk("start_after_accept", mult_start, 1);
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clock);
      #1;
      if (mult_done) ok = 1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done");
    end
  endtask

  task automatic drain(input string name);
    cdb_grant = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(negedge clock);
      #3;
    end
    chk({name, "_pending"}, exp_q.size(), 0);
    @(negedge clock);
    #1;
    chk({name, "_cdb_idle"}, cdb_valid, 0);
  endtask

  task automatic squash_cycle();
    @(negedge clock);
    squash = 1'b1;
    exp_q.delete();
    @(posedge clock);
    #1;
    squash = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_issue_ready"}, issue_ready, 0);
    chk({name, "_mult_start"}, mult_start, 0);
    chk({name, "_mult_rs1"}, mult_rs1, 0);
    chk({name, "_mult_rs2"}, mult_rs2, 0);
    chk({name, "_mult_func"}, mult_func, MUL);
    chk({name, "_cdb_valid"}, cdb_valid, 0);
    chk({name, "_cdb_result"}, cdb_result, 0);
    chk({name, "_cdb_tag"}, cdb_tag, 0);
    chk({name, "_state"}, dbg_state, MI_IDLE);
  endtask

  function automatic DATA pick();
    DATA c[5];
    c[0] = 32'h0; c[1] = 32'h1; c[2] = 32'hFFFF_FFFF; c[3] = 32'h8000_0000; c[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  // Main sequence.
  initial begin
    bit ok;
    bit got;
    MULT_FUNC f;
    DATA a;
    DATA b;
    int r;

    vecs[0] = '{MULH,   32'hC000_0000, 32'd4,         6'd10, 32'hFFFF_FFFF};
    vecs[1] = '{MULHU,  32'hC000_0000, 32'd4,         6'd11, 32'h0000_0003};
    vecs[2] = '{MULHSU, 32'hC000_0000, 32'd4,         6'd12, 32'hFFFF_FFFF};
    vecs[3] = '{MUL,    32'd7,         32'd6,         6'd13, 32'd42};
    vecs[4] = '{MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd14, 32'd1};
    vecs[5] = '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd15, 32'hFFFF_FFFE};
    vecs[6] = '{MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd16, 32'h0};
    vecs[7] = '{MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd63, 32'hFFFF_FFFF};

    reset = 1'b0; issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0;
    issue_func = MUL; issue_tag = '0; squash = 1'b0; cdb_grant = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check_reset_outputs("por");
    @(negedge clock);
    reset = 1'b1;

    // Basic op with grant held high; latency and issue_ready return.
    cdb_grant = 1'b1;
    issue_op(MUL, 32'd3, 32'd4, 6'd5, 32'd12);
    wait_done(ok);
    if (ok) begin
`ifdef MULT_CDB_BYPASS_EN
      chk("t1_bypass_valid", cdb_valid, 1);
      chk("t1_bypass_result", cdb_result, 12);
      chk("t1_bypass_tag", cdb_tag, 5);
      @(negedge clock);
      #1;
      chk("t1_buffer_stays_empty", cdb_valid, 0);
`else
      chk("t1_no_early_cdb", cdb_valid, 0);
      @(negedge clock);
      #1;
      chk("t1_cdb_valid", cdb_valid, 1);
      chk("t1_cdb_result", cdb_result, 12);
      chk("t1_cdb_tag", cdb_tag, 5);
`endif
      chk("t1_ready_back", issue_ready, 1);
    end
    drain("t1");

    // Vector table, results must appear in issue order.
    for (int i = 0; i < 8; i++) issue_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].t, vecs[i].exp);
    drain("table");

    // Backpressure: two buffered results block a third issue.
    cdb_grant = 1'b0;
    issue_op(MUL, 32'd2, 32'd3, 6'd1, 32'd6);
    wait_done(ok);
    issue_op(MUL, 32'd5, 32'd5, 6'd2, 32'd25);
    wait_done(ok);
    @(negedge clock);
    #1;
    chk("bp_full_ready", issue_ready, 0);
    chk("bp_head_valid", cdb_valid, 1);
    chk("bp_head_tag", cdb_tag, 1);
    issue_valid = 1'b1; issue_tag = 6'd9;
    repeat (2) begin
      @(negedge clock);
      #1;
      chk("bp_blocked_ready", issue_ready, 0);
      chk("bp_blocked_start", mult_start, 0);
    end
    issue_valid = 1'b0;
    cdb_grant = 1'b1;
    @(negedge clock);
    #1;
    chk("bp_second_valid", cdb_valid, 1);
    chk("bp_second_tag", cdb_tag, 2);
    chk("bp_ready_again", issue_ready, 1);
    @(negedge clock);
    #1;
    chk("bp_empty", cdb_valid, 0);
    drain("bp");

    // Squash while BUSY: drain the mult, discard, then resume.
    force_lat = 6;
    issue_op(MULHU, 32'hFFFF_FFFF, 32'd2, 6'd20, 32'd1);
    @(negedge clock);
    @(negedge clock);
    #1;
    chk("sq_busy_before", dbg_state, MI_BUSY);
    squash = 1'b1;
    exp_q.delete();
    issue_valid = 1'b1; issue_tag = 6'd21;
    @(posedge clock);
    #1;
    squash = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      #1;
      chk("sq_drain_state", dbg_state, MI_DRAIN);
      chk("sq_drain_ready", issue_ready, 0);
      chk("sq_drain_cdb", cdb_valid, 0);
      if (mult_done) got = 1;
    end
    issue_valid = 1'b0;
    chk("sq_drain_done_seen", got, 1);
    @(negedge clock);
    #1;
    chk("sq_after_state", dbg_state, MI_IDLE);
    chk("sq_after_cdb", cdb_valid, 0);
    force_lat = 0;
    issue_op(MUL, 32'd9, 32'd9, 6'd22, 32'd81);
    drain("sq_resume");

    // Squash in the same cycle as done: straight back to IDLE, no result.
    force_lat = 2;
    issue_op(MUL, 32'd7, 32'd7, 6'd23, 32'd49);
    wait_done(ok);
    squash = 1'b1;
    exp_q.delete();
    @(posedge clock);
    #1;
    squash = 1'b0;
    @(negedge clock);
    #1;
    chk("sqd_state", dbg_state, MI_IDLE);
    chk("sqd_cdb", cdb_valid, 0);
    force_lat = 0;

    // Squash together with a grant on a buffered result.
    cdb_grant = 1'b0;
    issue_op(MUL, 32'd6, 32'd7, 6'd24, 32'd42);
    wait_done(ok);
    @(negedge clock);
    #1;
    chk("sqg_buffered", cdb_valid, 1);
    cdb_grant = 1'b1;
    squash = 1'b1;
    exp_q.delete();
    @(posedge clock);
    #1;
    squash = 1'b0;
    cdb_grant = 1'b0;
    @(negedge clock);
    #1;
    chk("sqg_cleared", cdb_valid, 0);

    // Reset while BUSY with one buffered result.
    issue_op(MUL, 32'd11, 32'd3, 6'd40, 32'd33);
    wait_done(ok);
    force_lat = 8;
    issue_op(MUL, 32'd2, 32'd2, 6'd41, 32'd4);
    @(negedge clock);
    @(negedge clock);
    #1;
    chk("rst_pre_busy", dbg_state, MI_BUSY);
    chk("rst_pre_buffered", cdb_valid, 1);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clock);
    reset = 1'b1;
    force_lat = 0;
    cdb_grant = 1'b1;
    issue_op(MUL, 32'd0, 32'd1, 6'd3, 32'd0);
    drain("post_reset");

    // Randomized traffic with random grants and occasional squashes.
    rand_grant = 1;
    for (int i = 0; i < 120; i++) begin
      f = MULT_FUNC'($urandom_range(0, 3));
      a = pick();
      b = pick();
      issue_op(f, a, b, TW'($urandom_range(0, 63)), ref_mul(f, a, b));
      r = $urandom_range(0, 9);
      if (r == 0) squash_cycle();
      else if (r == 1) begin
        repeat (2) @(negedge clock);
        squash_cycle();
      end else if (r == 2) repeat ($urandom_range(1, 3)) @(negedge clock);
    end
    rand_grant = 0;
    drain("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
